mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner_if.sv | 19 +
 rtl/mux_scanner.sv | 94 +++++++++
 tb/tb_mux_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mux_scanner_if.sv
// Bus bundle for mux_scanner: packed channel inputs, manual select/mode/hold
// controls and the registered sample outputs.
interface mux_scanner_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] x;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      hold;
  logic [WIDTH-1:0]          m;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;

  modport master (output x, sel, mode, hold, input m, ch, valid, wrap);
  modport slave  (input x, sel, mode, hold, output m, ch, valid, wrap);
endinterface

// File: rtl/mux_scanner.sv
// Channel multiplexer with manual select and timed auto-scan; one-cycle
// registered output with valid strobe per dwell period and wrap pulse.
module mux_scanner #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_scanner_if.slave       bus
);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} mode_e;

  logic [WIDTH-1:0] m_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
  logic             wrap_q;
  logic [SEL_W-1:0] scan_ch_q;
  logic [DW-1:0]    dwell_q;

  mode_e            mode_d;
  logic [SEL_W-1:0] cur_d;
  logic [WIDTH-1:0] chan_d;
  logic             sel_legal_d;
  logic             dwell_end_d;
  logic             last_ch_d;

  assign mode_d      = mode_e'(bus.mode);
  assign cur_d       = (mode_d == SCAN) ? scan_ch_q : bus.sel;
  assign sel_legal_d = (32'(bus.sel) < CHANNELS);
  assign dwell_end_d = (dwell_q == DW'(DWELL - 1));
  assign last_ch_d   = (scan_ch_q == SEL_W'(CHANNELS - 1));

  // Explicit compare per channel keeps an out-of-range select reading as zero.
  always_comb begin
    chan_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cur_d == SEL_W'(k)) chan_d = bus.x[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      scan_ch_q <= '0;
      dwell_q   <= '0;
    end else if (bus.hold) begin
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (mode_d == MANUAL) begin
      ch_q    <= bus.sel;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      if (sel_legal_d) begin
        m_q       <= chan_d;
        valid_q   <= 1'b1;
        scan_ch_q <= bus.sel;
      end else begin
        m_q       <= '0;
        valid_q   <= 1'b0;
        scan_ch_q <= '0;
      end
    end else begin
      m_q  <= chan_d;
      ch_q <= scan_ch_q;
      if (dwell_end_d) begin
        dwell_q <= '0;
        valid_q <= 1'b1;
        if (last_ch_d) begin
          scan_ch_q <= '0;
          wrap_q    <= 1'b1;
        end else begin
          scan_ch_q <= scan_ch_q + SEL_W'(1);
          wrap_q    <= 1'b0;
        end
      end else begin
        dwell_q <= dwell_q + DW'(1);
        valid_q <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end
  end

  assign bus.m     = m_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench: 8-channel/DWELL=4 instance for manual, scan, hold, reset and
// mode-switch behaviour; 6-channel/DWELL=1 instance for illegal select.
module tb_mux_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_scanner_if #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) a_if ();
  mux_scanner_if #(.WIDTH(4), .CHANNELS(6), .SEL_W(3)) b_if ();

  mux_scanner #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  mux_scanner #(.WIDTH(4), .CHANNELS(6), .SEL_W(3), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  typedef struct {
    logic [2:0] sel;
    logic       mode;
    logic       hold;
    logic [3:0] m;
    logic [2:0] ch;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] m, input logic [2:0] ch,
                       input logic v, input logic w);
    chk({tag, ".m"},     32'(a_if.m),     32'(m));
    chk({tag, ".ch"},    32'(a_if.ch),    32'(ch));
    chk({tag, ".valid"}, 32'(a_if.valid), 32'(v));
    chk({tag, ".wrap"},  32'(a_if.wrap),  32'(w));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] m, input logic [2:0] ch,
                       input logic v, input logic w);
    chk({tag, ".m"},     32'(b_if.m),     32'(m));
    chk({tag, ".ch"},    32'(b_if.ch),    32'(ch));
    chk({tag, ".valid"}, 32'(b_if.valid), 32'(v));
    chk({tag, ".wrap"},  32'(b_if.wrap),  32'(w));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance a running scan until dut A shows the wanted channel; bounded.
  task automatic run_to_ch(input logic [2:0] want, input string tag);
    int n = 0;
    while (a_if.ch !== want && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".reached"}, 32'(a_if.ch), 32'(want));
  endtask

  initial begin
    logic [31:0] xa;
    logic [23:0] xb;
    for (int k = 0; k < 8; k++) xa[k*4 +: 4] = 4'(k + 1);
    for (int k = 0; k < 6; k++) xb[k*4 +: 4] = 4'(k + 1);
    a_if.x = xa; a_if.sel = '0; a_if.mode = 1'b0; a_if.hold = 1'b0;
    b_if.x = xb; b_if.sel = '0; b_if.mode = 1'b0; b_if.hold = 1'b0;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{3'(i), 1'b0, 1'b0, 4'(i + 1), 3'(i), 1'b1, 1'b0};
    vecs[8] = '{3'd2, 1'b0, 1'b1, 4'd8, 3'd7, 1'b0, 1'b0};
    vecs[9] = '{3'd2, 1'b0, 1'b0, 4'd3, 3'd2, 1'b1, 1'b0};

    // Reset overrides hold and mode.
    a_if.hold = 1'b1; a_if.mode = 1'b1;
    step(); step();
    chk_a("reset_a", 4'd0, 3'd0, 1'b0, 1'b0);
    chk_b("reset_b", 4'd0, 3'd0, 1'b0, 1'b0);
    a_if.hold = 1'b0; a_if.mode = 1'b0;
    reset = 1'b0;

    // Manual sweep and manual hold.
    for (int i = 0; i < 10; i++) begin
      a_if.sel = vecs[i].sel; a_if.mode = vecs[i].mode; a_if.hold = vecs[i].hold;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].m, vecs[i].ch, vecs[i].valid, vecs[i].wrap);
    end
    a_if.hold = 1'b0;

    // Full scan from reset.
    reset = 1'b1; step(); reset = 1'b0;
    a_if.mode = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk_a($sformatf("scan%0d", i), 4'((i - 1) / 4 + 1), 3'((i - 1) / 4),
            (i % 4) == 0, i == 32);
    end
    step();
    chk_a("scan33", 4'd1, 3'd0, 1'b0, 1'b0);

    // Hold at dwell_cnt=2.
    step();
    chk_a("pre_hold", 4'd1, 3'd0, 1'b0, 1'b0);
    a_if.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("hold%0d", i), 4'd1, 3'd0, 1'b0, 1'b0);
    end
    a_if.hold = 1'b0;
    step();
    chk_a("rel1", 4'd1, 3'd0, 1'b0, 1'b0);
    step();
    chk_a("rel2", 4'd1, 3'd0, 1'b1, 1'b0);

    // Reset mid-scan at ch=5.
    run_to_ch(3'd5, "to5");
    reset = 1'b1; step(); reset = 1'b0;
    chk_a("midrst", 4'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_a($sformatf("rstscan%0d", i), 4'd1, 3'd0, i == 4, 1'b0);
    end

    // Scan -> manual -> scan.
    run_to_ch(3'd3, "to3");
    a_if.mode = 1'b0; a_if.sel = 3'd6;
    step();
    chk_a("sw_man", 4'd7, 3'd6, 1'b1, 1'b0);
    a_if.mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_a($sformatf("sw_scan%0d", i), 4'd7, 3'd6, i == 4, 1'b0);
    end
    a_if.mode = 1'b0;

    // Illegal select on 6 channels, then DWELL=1 scan from channel 0.
    b_if.sel = 3'd7;
    step();
    chk_b("illegal", 4'd0, 3'd7, 1'b0, 1'b0);
    b_if.mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_b($sformatf("bscan%0d", i), 4'((i % 6) + 1), 3'(i % 6), 1'b1, i == 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
